// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Derives the SoC system reset from the PLL lock flag, holding
//               reset until lock has been stable and counting lock losses.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       locked,
    output logic       sys_reset,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] loss_count,
    output logic [1:0] state
);

    localparam int c_cnt_max = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max);

    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last   = c_cnt_w'(HOLD_CYCLES - 1);

    localparam logic [1:0] S_WAIT_LOCK = 2'd0;
    localparam logic [1:0] S_STABILIZE = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;
    localparam logic [1:0] S_FAULT     = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;
    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_next_cnt;
    logic                   w_loss;
    logic                   r_sys_reset;
    logic                   r_ready;
    logic                   r_lock_lost;
    logic [7:0]             r_loss_count;

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_loss       = 1'b0;
        case (r_state)
            S_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_next_state = S_STABILIZE;
                    w_next_cnt   = '0;
                end
            end
            S_STABILIZE: begin
                // A single low cycle throws away the whole stability window.
                if (!w_lock_s) begin
                    w_next_state = S_WAIT_LOCK;
                    w_next_cnt   = '0;
                end else if (r_cnt == c_stable_last) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    w_next_state = S_FAULT;
                    w_next_cnt   = '0;
                    w_loss       = 1'b1;
                end
            end
            S_FAULT: begin
                // Hold time is fixed; a returning lock does not cut it short.
                if (r_cnt == c_hold_last) begin
                    w_next_state = S_WAIT_LOCK;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = S_WAIT_LOCK;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_sync       <= '0;
            r_state      <= S_WAIT_LOCK;
            r_cnt        <= '0;
            r_sys_reset  <= 1'b1;
            r_ready      <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_loss_count <= 8'd0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], locked};
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            // Outputs decode the next state so they move with the state register.
            r_sys_reset <= (w_next_state != S_RUN);
            r_ready     <= (w_next_state == S_RUN);
            r_lock_lost <= w_loss;
            if (w_loss && (r_loss_count != 8'hFF)) begin
                r_loss_count <= r_loss_count + 8'd1;
            end
        end
    end

    assign sys_reset  = r_sys_reset;
    assign ready      = r_ready;
    assign lock_lost  = r_lock_lost;
    assign loss_count = r_loss_count;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Generates the system reset for the SoC from the PLL lock indication. Runs in the PLL output clock domain. It synchronizes the asynchronous `locked` flag and holds `sys_reset` asserted until lock has been continuously stable for a programmable interval. On loss of lock it re-asserts reset immediately and counts the loss events for debug. It sits between the `pll` wrapper and the CPU/peripheral reset inputs.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `locked`; must be ≥2.
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before reset release; must be ≥2.
- `HOLD_CYCLES`, 16: minimum cycles `sys_reset` stays asserted after a lock loss; must be ≥1.
- `clock_in`  in  1  PLL output clock; the only clock.
- `reset`  in  1  synchronous, active-high (board button / POR).
- `locked`  in  1  PLL lock flag, asynchronous to `clock_in`.
- `sys_reset`  out  1  active-high reset to the rest of the design; registered.
- `ready`  out  1  high only in RUN; registered.
- `lock_lost`  out  1  one-cycle pulse per lock loss detected in RUN.
- `loss_count`  out  8  lock-loss events since `reset`, saturating at 255.
- `state`  out  2  current FSM state: 0 WAIT_LOCK, 1 STABILIZE, 2 RUN, 3 FAULT.

## Operation
- `locked` passes through a `SYNC_STAGES`-flop chain; the last stage is `lock_s`. Only `lock_s` is used.
- One shared counter `cnt`, width `clog2(max(STABLE_CYCLES, HOLD_CYCLES))`.
- WAIT_LOCK: `sys_reset`=1, `ready`=0. If `lock_s`=1, go to STABILIZE with `cnt`=0.
- STABILIZE: `sys_reset`=1.
  - If `lock_s`=0, go to WAIT_LOCK. This is not counted as a loss and produces no `lock_lost`.
  - Else if `cnt`==`STABLE_CYCLES`-1, go to RUN.
  - Else `cnt`++.
- RUN: `sys_reset`=0, `ready`=1. If `lock_s`=0, then on the same edge:
  - go to FAULT with `cnt`=0;
  - `sys_reset`→1, `ready`→0;
  - `lock_lost`=1 for that one cycle;
  - `loss_count`++ unless already 255.
- FAULT: `sys_reset`=1. If `cnt`==`HOLD_CYCLES`-1, go to WAIT_LOCK regardless of `lock_s`; else `cnt`++. A lock return during FAULT does not shorten the hold.
- `sys_reset`, `ready` and `lock_lost` are registered and decoded from the next state, so they change on the same edge as `state`.
- `reset` has priority over all transitions, including a simultaneous lock loss.

## Timing
- Reset values, one edge after `reset`=1:
  - `state`=WAIT_LOCK, `sys_reset`=1, `ready`=0, `lock_lost`=0, `loss_count`=0, `cnt`=0;
  - all synchronizer flops=0.
- Reset release latency: with `locked` held high from edge 1 (the first edge sampling it high), `sys_reset` falls and `ready` rises after edge `SYNC_STAGES`+`STABLE_CYCLES`+1. That is edge 1027 at defaults, edge 11 with `STABLE_CYCLES`=8.
- Loss latency: `locked` first sampled low at edge 1 → `sys_reset`=1, `lock_lost`=1 after edge `SYNC_STAGES`+1 (3 at defaults). `lock_lost` returns to 0 one edge later.
- Minimum reset after loss: FAULT lasts exactly `HOLD_CYCLES` cycles, then at least 1 + `STABLE_CYCLES` more cycles before release.
- STABILIZE restart: any single cycle with `lock_s`=0 returns to WAIT_LOCK. The full `STABLE_CYCLES` count restarts from 0.
- `reset` asserted mid-operation, in any state: the next edge applies all reset values, including clearing `loss_count`. `sys_reset` never glitches low during this.
- `locked` pulses narrower than one `clock_in` period may be missed; this is acceptable.

## Test plan
- Reset: assert `reset` 3 cycles with `locked`=1 → `sys_reset`=1, `ready`=0, `state`=0, `loss_count`=0, `lock_lost`=0.
- Acquisition (`STABLE_CYCLES`=8): raise `locked` and hold → `sys_reset`=1 through edge 10, 0 after edge 11; `state` sequence 0→1→2.
- Glitch during STABILIZE: `locked` low 2 cycles at count 5 → `state` returns to 0; release occurs 11 edges after `locked` returns; `loss_count` stays 0; no `lock_lost`.
- Loss in RUN (`HOLD_CYCLES`=4):
  - drop `locked` → `sys_reset`=1 and a single `lock_lost` pulse after edge 3; `loss_count`=1;
  - `state`=3 for exactly 4 cycles, then 0, then re-acquires if `locked`=1.
- Saturation: 260 loss/reacquire cycles → `loss_count`=255; `lock_lost` still pulses each time.
- Mid-operation reset: assert `reset` in STABILIZE at count 6 and again in FAULT → next edge all reset values; release time counts from scratch.
